// File: rtl/axis_trigger_capture.sv
// rtl/axis_trigger_capture.sv - ADC ring-buffer trigger capture with AXI-Stream frame replay
// Define AXIS_TRG_TIMESTAMP_EN to prepend the trigger-sample timestamp beat to every frame.
module axis_trigger_capture #(
   parameter int DEPTH_LOG2 = 8,
   parameter int TS_WIDTH   = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_axis_tvalid,
   input  logic [31:0]           s_axis_tdata,
   input  logic [15:0]           trg_lvl,
   input  logic [DEPTH_LOG2-1:0] pre_len,
   input  logic [DEPTH_LOG2:0]   post_len,
   input  logic                  arm,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [31:0]           m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  trg_pulse
);

   localparam int DW    = DEPTH_LOG2;
   localparam int DEPTH = 1 << DW;
   localparam logic [DW:0] DEPTH_V = {1'b1, {DW{1'b0}}};
   localparam logic [DW:0] ONE_V   = {{DW{1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FILL    = 3'd1;
   localparam logic [2:0] S_ARMED   = 3'd2;
   localparam logic [2:0] S_POST    = 3'd3;
   localparam logic [2:0] S_READOUT = 3'd4;

   logic [2:0]    state;
   logic [31:0]   mem [DEPTH];
   logic [DW-1:0] wr_ptr, rd_ptr, pre_q;
   logic [DW:0]   post_q, fill_cnt, post_cnt;
   logic [DW+1:0] beats_q, iss_cnt;
   logic [15:0]   prev_a;
   logic          prev_vld;
   logic [31:0]   rd_data, out_data, ts_beat;
   logic          p_valid, p_last, p_ts, out_valid, out_last;

   logic [DW:0]   post_req, post_clip, frame_len;
   logic [DW+1:0] len_sum, beats_arm;
   logic          wr_en, trig_hit, load_out, issue, iss_ts, rd_en, last_hs;

`ifdef AXIS_TRG_TIMESTAMP_EN
   localparam logic [DW+1:0] EXTRA_BEATS = {{(DW+1){1'b0}}, 1'b1};
   logic [TS_WIDTH-1:0] ts_cnt, trg_ts;

   always_ff @(posedge aclk) begin
      if (areset) begin
         ts_cnt <= '0;
         trg_ts <= '0;
      end else begin
         if (s_axis_tvalid)
            ts_cnt <= ts_cnt + 1'b1;
         if (trig_hit)
            trg_ts <= ts_cnt;
      end
   end

   assign ts_beat = 32'(trg_ts);
   assign iss_ts  = (iss_cnt == '0);
`else
   localparam logic [DW+1:0] EXTRA_BEATS = '0;
   logic unused_ts_cfg;
   assign unused_ts_cfg = ^TS_WIDTH;
   assign ts_beat = '0;
   assign iss_ts  = 1'b0;
`endif

   // Window clipping: a zero post length still captures the trigger sample itself.
   always_comb begin
      post_req  = (post_len == '0) ? ONE_V : post_len;
      len_sum   = {2'b00, pre_len} + {1'b0, post_req};
      post_clip = (len_sum > {1'b0, DEPTH_V}) ? (DEPTH_V - {1'b0, pre_len}) : post_req;
      frame_len = {1'b0, pre_len} + post_clip;
      beats_arm = {1'b0, frame_len} + EXTRA_BEATS;
   end

   assign wr_en = s_axis_tvalid &&
                  ((state == S_FILL) || (state == S_ARMED) || (state == S_POST));

   assign trig_hit = (state == S_ARMED) && s_axis_tvalid && prev_vld &&
                     ($signed(prev_a) < $signed(trg_lvl)) &&
                     ($signed(s_axis_tdata[15:0]) >= $signed(trg_lvl));

   // Two-stage read pipe: RAM data register feeds the output register whenever it is free or draining.
   assign load_out = p_valid && (!out_valid || m_axis_tready);
   assign issue    = (state == S_READOUT) && (iss_cnt != beats_q) && (!p_valid || load_out);
   assign rd_en    = issue && !iss_ts;
   assign last_hs  = out_valid && m_axis_tready && out_last;

   always_ff @(posedge aclk) begin
      if (wr_en)
         mem[wr_ptr] <= s_axis_tdata;
      if (rd_en)
         rd_data <= mem[rd_ptr];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pre_q     <= '0;
         post_q    <= '0;
         fill_cnt  <= '0;
         post_cnt  <= '0;
         beats_q   <= '0;
         iss_cnt   <= '0;
         prev_a    <= '0;
         prev_vld  <= 1'b0;
         p_valid   <= 1'b0;
         p_last    <= 1'b0;
         p_ts      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr   <= wr_ptr + 1'b1;
            prev_a   <= s_axis_tdata[15:0];
            prev_vld <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (arm) begin
                  state    <= S_FILL;
                  pre_q    <= pre_len;
                  post_q   <= post_clip;
                  beats_q  <= beats_arm;
                  fill_cnt <= '0;
                  iss_cnt  <= '0;
                  prev_vld <= 1'b0;
               end
            end
            S_FILL: begin
               if (fill_cnt >= {1'b0, pre_q})
                  state <= S_ARMED;
               else if (s_axis_tvalid)
                  fill_cnt <= fill_cnt + 1'b1;
            end
            S_ARMED: begin
               if (trig_hit) begin
                  rd_ptr   <= wr_ptr - pre_q;
                  post_cnt <= post_q - 1'b1;
                  state    <= (post_q == ONE_V) ? S_READOUT : S_POST;
               end
            end
            S_POST: begin
               if (s_axis_tvalid) begin
                  post_cnt <= post_cnt - 1'b1;
                  if (post_cnt == ONE_V)
                     state <= S_READOUT;
               end
            end
            S_READOUT: begin
               if (last_hs)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (issue) begin
            iss_cnt <= iss_cnt + 1'b1;
            p_last  <= (iss_cnt == beats_q - 1'b1);
            p_ts    <= iss_ts;
            p_valid <= 1'b1;
            if (!iss_ts)
               rd_ptr <= rd_ptr + 1'b1;
         end else if (load_out) begin
            p_valid <= 1'b0;
         end

         if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= p_ts ? ts_beat : rd_data;
            out_last  <= p_last;
         end else if (out_valid && m_axis_tready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_data;
   assign m_axis_tlast  = out_last;
   assign busy          = (state != S_IDLE);
   assign trg_pulse     = trig_hit && !areset;

endmodule
